// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

    localparam int UART_DATA_W = 8;
    localparam int UART_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through circular FIFO; pointers carry one extra
// wrap bit so full and empty are told apart by the MSB.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    always_comb begin
        empty = wr_ptr_q == rd_ptr_q;
        full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop = pop && !empty;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        do_push = push && (!full || do_pop);
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q[AW-1:0]] = din;
        wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/uart_rx_intrpt.sv
// uart_rx_intrpt: 8N1 UART receiver with byte FIFO, level interrupt and sticky errors.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_rx_intrpt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH = 4
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_serial,
    input  logic                   rd_en,
    input  logic                   clr_err,
    input  logic                   ack_intrpt,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   intrpt,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    rx_state_t              state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [UART_DATA_W-1:0] shreg_q, shreg_d;
    logic                   perr_q, perr_d;
    logic                   push_q, push_d;
    logic                   intrpt_q, intrpt_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   rx_s, stop_hit, fifo_full, fifo_empty, push_ok;

    assign rx_s = sync_q[1];
    assign stop_hit = (state_q == STOP) && (cnt_q == CNT_LAST);

    always_comb begin
        sync_d = {sync_q[0], rx_serial};
        state_d = state_q;
        cnt_d = cnt_q + CW'(1);
        bit_d = bit_q;
        shreg_d = shreg_q;
        perr_d = perr_q;
        push_d = stop_hit && rx_s && !perr_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                perr_d = 1'b0;
                state_d = rx_s ? IDLE : START;
            end
            // half a bit in: a high line here was a glitch, not a start bit
            START: if (cnt_q == CNT_HALF) begin
                cnt_d = '0;
                bit_d = '0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                shreg_d = {rx_s, shreg_q[UART_DATA_W-1:1]};
                bit_d = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (bit_q == 3'd7) state_d = PARITY;
`else
                if (bit_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                perr_d = rx_s != (^shreg_q ^ PARITY_ODD);
                state_d = STOP;
            end
`endif
            STOP: if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push_ok = push_q && (!fifo_full || rd_en);
        intrpt_d = push_ok || (intrpt_q && !ack_intrpt);
        frame_err_d = (stop_hit && !rx_s) || (frame_err_q && !clr_err);
        overrun_d = (push_q && fifo_full && !rd_en) || (overrun_q && !clr_err);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
            state_q <= IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            shreg_q <= '0;
            perr_q <= 1'b0;
            push_q <= 1'b0;
            intrpt_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            shreg_q <= shreg_d;
            perr_q <= perr_d;
            push_q <= push_d;
            intrpt_q <= intrpt_d;
            frame_err_q <= frame_err_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q, parity_err_d;

    always_comb parity_err_d = (stop_hit && rx_s && perr_q) || (parity_err_q && !clr_err);

    always_ff @(posedge clk) begin
        if (reset) parity_err_q <= 1'b0;
        else parity_err_q <= parity_err_d;
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(UART_DATA_W)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push_q),
        .din  (shreg_q),
        .pop  (rd_en),
        .full (fifo_full),
        .empty(fifo_empty),
        .head (rx_data)
    );

    assign rx_valid = !fifo_empty;
    assign intrpt = intrpt_q;
    assign frame_err = frame_err_q;
    assign overrun = overrun_q;

endmodule
